mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Controls the MEM stage's access to a multi-cycle data memory that uses a req/ack handshake.
- Sits between the EX/MEM pipeline register outputs (MemRead, MemWrite, ALU result used as the address, RS2 data used as write data) and the data-memory port.
- Posts stores into a 1-entry write buffer so the pipeline does not stall on them.
- Stalls loads until data returns; a load that hits the buffered store's address is forwarded without stalling.
- Drives stall_o, which freezes PC, IF/ID, ID/EX and EX/MEM and inserts a bubble into MEM/WB.

Parameters:
- TIMEOUT, 255, maximum cycles mem_req_o may stay high without mem_ack_i before abort; counter is 8 bits; legal range 1..255.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- MemRead_i  input  1  load request from EX/MEM.
- MemWrite_i  input  1  store request from EX/MEM.
- addr_i  input  32  byte address (ALU result); word access; addr_i[1:0] ignored.
- wdata_i  input  32  store data (RS2 data).
- rdata_o  output  32  load data to MEM/WB.
- stall_o  output  1  combinational; high freezes the pipeline.
- err_o  output  1  sticky timeout flag; cleared only by reset.
- mem_req_o  output  1  registered memory request.
- mem_we_o  output  1  registered; 1 = write, 0 = read.
- mem_addr_o  output  32  registered; word-aligned (bits [1:0] = 0).
- mem_wdata_o  output  32  registered write data.
- mem_ack_i  input  1  one-cycle acknowledge; with a read, mem_rdata_i is valid in the same cycle.
- mem_rdata_i  input  32  read data.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State goes to IDLE; write buffer valid (wb_v) cleared; timeout counter = 0.
  - rdata_q, err_o, mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o all = 0.
  - stall_o is forced 0 while rst_i=0.
  - Reset mid-transaction abandons the access; no ack is tracked afterwards.
- Request decode: MemWrite_i has priority. If both MemRead_i and MemWrite_i are 1, the access is a store and MemRead_i is ignored.
- Address match: hit = wb_v & (addr_i[31:2] == wb_addr[31:2]).
- States: IDLE, WR_BUSY (buffered store in flight), RD_BUSY (load in flight), RD_DONE.
- IDLE, store:
  - wb_v is 0 here; latch addr and data into the buffer.
  - stall_o = 0; go to WR_BUSY.
  - Next cycle: mem_req_o = 1, mem_we_o = 1, mem_addr_o and mem_wdata_o from the buffer.
- IDLE, load:
  - stall_o = 1; go to RD_BUSY.
  - Next cycle: mem_req_o = 1, mem_we_o = 0.
- WR_BUSY:
  - mem_req_o and its fields are held stable until mem_ack_i.
  - On ack: mem_req_o drops next cycle, wb_v is cleared, go to IDLE.
  - A new store in this state: stall_o = 1 until the ack cycle. In the ack cycle stall_o = 0, the new store is latched into the buffer, and the state stays WR_BUSY with a new request issued the following cycle (back-to-back).
  - A load with hit: stall_o = 0 and rdata_o = wb_data (combinational forward).
  - A load with miss: stall_o = 1. On ack, go to RD_BUSY instead of IDLE.
- RD_BUSY:
  - stall_o = 1.
  - On ack: rdata_q <= mem_rdata_i, mem_req_o drops, go to RD_DONE.
- RD_DONE:
  - Lasts one cycle; stall_o = 0 and rdata_o = rdata_q, so the pipeline advances.
  - Then IDLE. A new request is not accepted in RD_DONE.
- rdata_o mux:
  - forwarded buffer data when a load hits in WR_BUSY;
  - otherwise rdata_q.
  - rdata_q keeps its value until the next read ack.
- No request: stall_o = 0 in IDLE and in WR_BUSY.
- Timeout:
  - The counter increments each cycle with mem_req_o = 1 and mem_ack_i = 0, and clears on ack or on a new request.
  - When it reaches TIMEOUT: err_o <= 1 (sticky), mem_req_o <= 0, wb_v <= 0, rdata_q <= 0, and the state goes to IDLE (from RD_BUSY, via RD_DONE).
  - A stalled requester then re-enters the normal flow from IDLE.
- mem_ack_i arriving while mem_req_o = 0 is ignored.

Test Plan:
1. Reset mid-flight: assert rst_i=0 while a load is in RD_BUSY -> in the same cycle mem_req_o=0, stall_o=0, err_o=0, rdata_o=0; after release with no requests, mem_req_o stays 0.
2. Store with ack after 3 cycles: MemWrite_i=1, addr 0x104, data 0xDEADBEEF for one cycle -> stall_o=0 throughout; mem_req_o=1, mem_we_o=1, mem_addr_o=0x104, mem_wdata_o=0xDEADBEEF for 3 cycles; mem_req_o=0 after the ack.
3. Load with ack latency 2: MemRead_i=1, addr 0x200, memory returns 0x12345678 -> stall_o=1 for 3 cycles, then one RD_DONE cycle with stall_o=0 and rdata_o=0x12345678.
4. Store 0xA5A5A5A5 to 0x40, then a load from 0x43 next cycle (ack withheld) -> stall_o=0, rdata_o=0xA5A5A5A5, no read request issued. A load from 0x80 instead -> stall until the write ack, then a read request to 0x80.
5. Back-to-back stores to 0x0 and then 0x4 -> second store stalls until the first ack, then mem_addr_o=0x4 one cycle after the ack; no cycle gap with wb_v=0.
6. TIMEOUT=4 and a load that is never acked -> mem_req_o high for 4 cycles, then 0; err_o=1 and stays 1; rdata_o=0; stall_o released next cycle; err_o cleared only by reset.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory access controller.
// Sits between the EX/MEM register and a multi-cycle req/ack data memory.
// Stores are posted into a one-entry write buffer so they do not stall the
// pipeline; loads stall until their data returns, except when they hit the
// buffered store, in which case the store data is forwarded directly.
//
// Memory handshake: mem_req_o and its fields (mem_we_o, mem_addr_o,
// mem_wdata_o) are registered and held stable while mem_req_o is high until
// the memory returns a one-cycle mem_ack_i; for a read, mem_rdata_i is valid
// in the ack cycle. The transfer completes in the cycle where mem_req_o and
// mem_ack_i are both high. An ack seen while mem_req_o is low is ignored.
// If TIMEOUT cycles pass with no ack, the access is abandoned and err_o is
// set until reset.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic [1:0]  stateDbg_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2,
        RD_DONE = 2'd3
    } state_t;

    // Counter value whose next ackless cycle is the TIMEOUT-th one.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state, stateNxt;
    logic        wbV, wbVNxt;
    logic [29:0] wbAddr, wbAddrNxt;
    logic [31:0] wbData, wbDataNxt;
    logic [31:0] rdataQ, rdataQNxt;
    logic        errQ, errNxt;
    logic        memReq, reqNxt;
    logic        memWe, weNxt;
    logic [31:0] memAddr, addrNxt;
    logic [31:0] memWdata, wdataNxt;
    logic [7:0]  toCnt, cntNxt;

    logic        isStore, isLoad, hit, ackSeen, toExpire;
    logic        stallC, fwd;
    logic [31:0] alignedAddr;
    logic        unusedAddrBits;

    // Word access only: the byte offset does not take part in anything.
    assign unusedAddrBits = ^addr_i[1:0];
    assign alignedAddr    = {addr_i[31:2], 2'b00};

    // A store takes priority when both request bits are set.
    assign isStore  = MemWrite_i;
    assign isLoad   = MemRead_i & ~MemWrite_i;
    assign hit      = wbV & (addr_i[31:2] == wbAddr);
    assign ackSeen  = memReq & mem_ack_i;
    assign toExpire = memReq & ~mem_ack_i & (toCnt == TO_LAST);

    // Next-state, datapath next values, stall and forward select.
    always_comb begin
        stateNxt  = state;
        wbVNxt    = wbV;
        wbAddrNxt = wbAddr;
        wbDataNxt = wbData;
        rdataQNxt = rdataQ;
        errNxt    = errQ;
        reqNxt    = memReq;
        weNxt     = memWe;
        addrNxt   = memAddr;
        wdataNxt  = memWdata;
        cntNxt    = toCnt;
        stallC    = 1'b0;
        fwd       = 1'b0;

        case (state)
            IDLE: begin
                if (isStore) begin
                    wbVNxt    = 1'b1;
                    wbAddrNxt = addr_i[31:2];
                    wbDataNxt = wdata_i;
                    reqNxt    = 1'b1;
                    weNxt     = 1'b1;
                    addrNxt   = alignedAddr;
                    wdataNxt  = wdata_i;
                    cntNxt    = 8'd0;
                    stateNxt  = WR_BUSY;
                end else if (isLoad) begin
                    stallC   = 1'b1;
                    reqNxt   = 1'b1;
                    weNxt    = 1'b0;
                    addrNxt  = alignedAddr;
                    cntNxt   = 8'd0;
                    stateNxt = RD_BUSY;
                end
            end

            WR_BUSY: begin
                // A load to the buffered word is served from the buffer.
                fwd = isLoad & hit;
                if (ackSeen) begin
                    cntNxt   = 8'd0;
                    reqNxt   = 1'b0;
                    wbVNxt   = 1'b0;
                    stateNxt = IDLE;
                    if (isStore) begin
                        // Back-to-back store: refill the buffer in the ack
                        // cycle so it never goes empty in between.
                        wbVNxt    = 1'b1;
                        wbAddrNxt = addr_i[31:2];
                        wbDataNxt = wdata_i;
                        reqNxt    = 1'b1;
                        weNxt     = 1'b1;
                        addrNxt   = alignedAddr;
                        wdataNxt  = wdata_i;
                        stateNxt  = WR_BUSY;
                    end else if (isLoad && !hit) begin
                        stallC   = 1'b1;
                        reqNxt   = 1'b1;
                        weNxt    = 1'b0;
                        addrNxt  = alignedAddr;
                        stateNxt = RD_BUSY;
                    end
                end else if (toExpire) begin
                    stallC    = isStore | (isLoad & ~hit);
                    errNxt    = 1'b1;
                    reqNxt    = 1'b0;
                    wbVNxt    = 1'b0;
                    rdataQNxt = 32'd0;
                    cntNxt    = 8'd0;
                    stateNxt  = IDLE;
                end else begin
                    stallC = isStore | (isLoad & ~hit);
                    cntNxt = toCnt + 8'd1;
                end
            end

            RD_BUSY: begin
                stallC = 1'b1;
                if (ackSeen) begin
                    rdataQNxt = mem_rdata_i;
                    reqNxt    = 1'b0;
                    cntNxt    = 8'd0;
                    stateNxt  = RD_DONE;
                end else if (toExpire) begin
                    // Abandoned load still passes through RD_DONE so the
                    // stalled instruction advances, with zero data.
                    errNxt    = 1'b1;
                    reqNxt    = 1'b0;
                    rdataQNxt = 32'd0;
                    cntNxt    = 8'd0;
                    stateNxt  = RD_DONE;
                end else begin
                    cntNxt = toCnt + 8'd1;
                end
            end

            RD_DONE: begin
                // One release cycle; the request held on the inputs is the
                // load that just completed, so it is not re-accepted.
                stateNxt = IDLE;
            end

            default: begin
                stateNxt = IDLE;
            end
        endcase
    end

    // State register plus all registered datapath and memory-port fields.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            wbV      <= 1'b0;
            wbAddr   <= 30'd0;
            wbData   <= 32'd0;
            rdataQ   <= 32'd0;
            errQ     <= 1'b0;
            memReq   <= 1'b0;
            memWe    <= 1'b0;
            memAddr  <= 32'd0;
            memWdata <= 32'd0;
            toCnt    <= 8'd0;
        end else begin
            state    <= stateNxt;
            wbV      <= wbVNxt;
            wbAddr   <= wbAddrNxt;
            wbData   <= wbDataNxt;
            rdataQ   <= rdataQNxt;
            errQ     <= errNxt;
            memReq   <= reqNxt;
            memWe    <= weNxt;
            memAddr  <= addrNxt;
            memWdata <= wdataNxt;
            toCnt    <= cntNxt;
        end
    end

    // Output drive; stall is suppressed while reset is held.
    always_comb begin
        rdata_o     = fwd ? wbData : rdataQ;
        stall_o     = rst_i & stallC;
        err_o       = errQ;
        mem_req_o   = memReq;
        mem_we_o    = memWe;
        mem_addr_o  = memAddr;
        mem_wdata_o = memWdata;
        stateDbg_o  = state;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl (TIMEOUT=4) with hand-computed values.
module tb_mem_access_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        MemRead_i, MemWrite_i;
    logic [31:0] addr_i, wdata_i;
    logic [31:0] rdata_o;
    logic        stall_o, err_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic [1:0]  stateDbg_o;

    int checks   = 0;
    int failures = 0;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stateDbg_o  (stateDbg_o)
    );

    // Clock: 10 time-unit period.
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic ack, input logic [31:0] rdat);
        MemRead_i   = rd;
        MemWrite_i  = wr;
        addr_i      = a;
        wdata_i     = d;
        mem_ack_i   = ack;
        mem_rdata_i = rdat;
        #1;
    endtask

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i = 1'b0;
        drive(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0);
        repeat (2) tick();
        // Reset state; stall forced low even with a load presented.
        checkEq("rst_stall", 32'(stall_o), 32'd0);
        checkEq("rst_req", 32'(mem_req_o), 32'd0);
        checkEq("rst_we", 32'(mem_we_o), 32'd0);
        checkEq("rst_addr", mem_addr_o, 32'd0);
        checkEq("rst_wdata", mem_wdata_o, 32'd0);
        checkEq("rst_err", 32'(err_o), 32'd0);
        checkEq("rst_rdata", rdata_o, 32'd0);
        checkEq("rst_state", 32'(stateDbg_o), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        rst_i = 1'b1;
        tick();
        checkEq("idle_req", 32'(mem_req_o), 32'd0);

        // Store, acked in the third request cycle.
        drive(1'b0, 1'b1, 32'h104, 32'hDEADBEEF, 1'b0, 32'h0);
        checkEq("st_stall0", 32'(stall_o), 32'd0);
        checkEq("st_req_pre", 32'(mem_req_o), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkEq("st_req1", 32'(mem_req_o), 32'd1);
        checkEq("st_we", 32'(mem_we_o), 32'd1);
        checkEq("st_addr", mem_addr_o, 32'h104);
        checkEq("st_wdata", mem_wdata_o, 32'hDEADBEEF);
        checkEq("st_stall1", 32'(stall_o), 32'd0);
        checkEq("st_state", 32'(stateDbg_o), 32'd1);
        tick();
        checkEq("st_req2", 32'(mem_req_o), 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        checkEq("st_req3", 32'(mem_req_o), 32'd1);
        checkEq("st_stall3", 32'(stall_o), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkEq("st_req_done", 32'(mem_req_o), 32'd0);
        checkEq("st_state_done", 32'(stateDbg_o), 32'd0);

        // Load, ack latency 2.
        drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'h0);
        checkEq("ld_stall0", 32'(stall_o), 32'd1);
        checkEq("ld_req0", 32'(mem_req_o), 32'd0);
        tick();
        checkEq("ld_req1", 32'(mem_req_o), 32'd1);
        checkEq("ld_we1", 32'(mem_we_o), 32'd0);
        checkEq("ld_addr1", mem_addr_o, 32'h200);
        checkEq("ld_stall1", 32'(stall_o), 32'd1);
        tick();
        drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, 32'h12345678);
        checkEq("ld_stall2", 32'(stall_o), 32'd1);
        tick();
        drive(1'b1, 1'b0, 32'h200, 32'h0, 1'b0, 32'hFFFFFFFF);
        checkEq("ld_done_state", 32'(stateDbg_o), 32'd3);
        checkEq("ld_done_stall", 32'(stall_o), 32'd0);
        checkEq("ld_done_rdata", rdata_o, 32'h12345678);
        checkEq("ld_done_req", 32'(mem_req_o), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkEq("ld_idle_state", 32'(stateDbg_o), 32'd0);
        checkEq("ld_hold_rdata", rdata_o, 32'h12345678);

        // Store then load hitting the buffer (byte offset ignored).
        drive(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 1'b0, 32'h0);
        checkEq("hit_st_stall", 32'(stall_o), 32'd0);
        tick();
        drive(1'b1, 1'b0, 32'h43, 32'h0, 1'b0, 32'h0);
        checkEq("hit_stall", 32'(stall_o), 32'd0);
        checkEq("hit_rdata", rdata_o, 32'hA5A5A5A5);
        checkEq("hit_we", 32'(mem_we_o), 32'd1);
        checkEq("hit_addr", mem_addr_o, 32'h40);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        checkEq("hit_no_rd_we", 32'(mem_we_o), 32'd1);
        checkEq("hit_no_rd_addr", mem_addr_o, 32'h40);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkEq("hit_req_done", 32'(mem_req_o), 32'd0);

        // Store then load missing the buffer.
        drive(1'b0, 1'b1, 32'h40, 32'h11111111, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
        checkEq("miss_stall1", 32'(stall_o), 32'd1);
        tick();
        drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 32'h0);
        checkEq("miss_stall_ack", 32'(stall_o), 32'd1);
        checkEq("miss_wr_we", 32'(mem_we_o), 32'd1);
        checkEq("miss_wr_addr", mem_addr_o, 32'h40);
        tick();
        drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
        checkEq("miss_rd_req", 32'(mem_req_o), 32'd1);
        checkEq("miss_rd_we", 32'(mem_we_o), 32'd0);
        checkEq("miss_rd_addr", mem_addr_o, 32'h80);
        checkEq("miss_rd_state", 32'(stateDbg_o), 32'd2);
        checkEq("miss_rd_stall", 32'(stall_o), 32'd1);
        checkEq("miss_old_rdata", rdata_o, 32'h12345678);
        drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b1, 32'hCAFEF00D);
        checkEq("miss_ack_stall", 32'(stall_o), 32'd1);
        tick();
        drive(1'b1, 1'b0, 32'h80, 32'h0, 1'b0, 32'h0);
        checkEq("miss_done_rdata", rdata_o, 32'hCAFEF00D);
        checkEq("miss_done_stall", 32'(stall_o), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Back-to-back stores.
        drive(1'b0, 1'b1, 32'h0, 32'hAAAA0000, 1'b0, 32'h0);
        checkEq("b2b_stall0", 32'(stall_o), 32'd0);
        tick();
        drive(1'b0, 1'b1, 32'h4, 32'hBBBB0004, 1'b0, 32'h0);
        checkEq("b2b_stall1", 32'(stall_o), 32'd1);
        checkEq("b2b_addr1", mem_addr_o, 32'h0);
        tick();
        checkEq("b2b_stall2", 32'(stall_o), 32'd1);
        drive(1'b0, 1'b1, 32'h4, 32'hBBBB0004, 1'b1, 32'h0);
        checkEq("b2b_stall_ack", 32'(stall_o), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkEq("b2b_req", 32'(mem_req_o), 32'd1);
        checkEq("b2b_addr", mem_addr_o, 32'h4);
        checkEq("b2b_wdata", mem_wdata_o, 32'hBBBB0004);
        checkEq("b2b_state", 32'(stateDbg_o), 32'd1);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkEq("b2b_req_done", 32'(mem_req_o), 32'd0);

        // Load never acked: timeout after 4 request cycles.
        drive(1'b1, 1'b0, 32'h300, 32'h0, 1'b0, 32'h0);
        checkEq("to_stall0", 32'(stall_o), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkEq("to_req_hi", 32'(mem_req_o), 32'd1);
            checkEq("to_err_lo", 32'(err_o), 32'd0);
        end
        tick();
        checkEq("to_req_lo", 32'(mem_req_o), 32'd0);
        checkEq("to_err", 32'(err_o), 32'd1);
        checkEq("to_stall_rel", 32'(stall_o), 32'd0);
        checkEq("to_rdata", rdata_o, 32'd0);
        checkEq("to_state", 32'(stateDbg_o), 32'd3);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        checkEq("to_err_sticky", 32'(err_o), 32'd1);
        checkEq("to_idle", 32'(stateDbg_o), 32'd0);

        // Ack with no outstanding request is ignored.
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h77777777);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkEq("stray_req", 32'(mem_req_o), 32'd0);
        checkEq("stray_rdata", rdata_o, 32'd0);

        // Read and write together decode as a store.
        drive(1'b1, 1'b1, 32'h20, 32'h5555AAAA, 1'b0, 32'h0);
        checkEq("both_stall", 32'(stall_o), 32'd0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        checkEq("both_we", 32'(mem_we_o), 32'd1);
        checkEq("both_addr", mem_addr_o, 32'h20);
        checkEq("both_err", 32'(err_o), 32'd1);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkEq("both_req_done", 32'(mem_req_o), 32'd0);

        // Load with nonzero data so reset below has something to clear.
        drive(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h24, 32'h0, 1'b1, 32'h5A5A5A5A);
        tick();
        drive(1'b1, 1'b0, 32'h24, 32'h0, 1'b0, 32'h0);
        checkEq("pre_rst_rdata", rdata_o, 32'h5A5A5A5A);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);

        // Reset mid-flight during a load in RD_BUSY.
        drive(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, 32'h0);
        tick();
        checkEq("mf_stall", 32'(stall_o), 32'd1);
        checkEq("mf_req", 32'(mem_req_o), 32'd1);
        #1;
        rst_i = 1'b0;
        #1;
        checkEq("mf_rst_req", 32'(mem_req_o), 32'd0);
        checkEq("mf_rst_stall", 32'(stall_o), 32'd0);
        checkEq("mf_rst_err", 32'(err_o), 32'd0);
        checkEq("mf_rst_rdata", rdata_o, 32'd0);
        tick();
        rst_i = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
        checkEq("mf_post_req1", 32'(mem_req_o), 32'd0);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        checkEq("mf_post_req2", 32'(mem_req_o), 32'd0);
        checkEq("mf_post_state", 32'(stateDbg_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
